// File: rtl/uart_pkg.sv
// Shared definitions for the UART response-frame transmitter: frame mode codes,
// frame FSM states and the bit-serial CRC-16 step.
package uart_pkg;

  localparam logic [7:0] COM_ACK = 8'h00;
  localparam logic [7:0] COM_RD  = 8'h80;

  // The state names the byte currently on the wire.
  typedef enum logic [2:0] {
    S_IDLE,
    S_COM,
    S_LEN,
    S_ADR,
    S_PAY,
    S_CRC_H,
    S_CRC_L
  } frame_state_e;

  function automatic logic [15:0] crc16_step(input logic [15:0] crc,
                                             input logic        b,
                                             input logic [15:0] poly);
    logic fb;
    fb = crc[15] ^ b;
    return {crc[14:0], 1'b0} ^ (fb ? poly : 16'h0000);
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// One 8N1/8N2 UART character: start bit, 8 data bits LSB first, STOP_BITS stop bits,
// each BAUD_DIV clocks long. A load on the byte_end cycle chains bytes with no gap.
module uart_tx_byte #(
  parameter int BAUD_DIV  = 434,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] dat,
  output logic       txd,
  output logic       bit_ce,
  output logic       byte_end
);

  localparam int             CW       = $clog2(BAUD_DIV);
  localparam logic [CW-1:0]  CNT_MAX  = CW'(BAUD_DIV - 1);
  localparam logic [3:0]     LAST_BIT = 4'(8 + STOP_BITS);

  logic [CW-1:0] cnt;
  logic [3:0]    bit_idx;
  logic [9:0]    sh;
  logic          active;
  logic          cell_end;

  assign cell_end = active && (cnt == CNT_MAX);
  assign byte_end = cell_end && (bit_idx == LAST_BIT);
  // First clock of each data-bit cell; txd already shows that bit.
  assign bit_ce   = active && (cnt == '0) && (bit_idx != 4'd0) && (bit_idx <= 4'd8);

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples values from before the edge regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      bit_idx <= '0;
      sh      <= '1;
      active  <= 1'b0;
      txd     <= 1'b1;
    end else if (load) begin
      cnt     <= '0;
      bit_idx <= '0;
      sh      <= {2'b11, dat};
      active  <= 1'b1;
      txd     <= 1'b0;
    end else if (active) begin
      if (cell_end) begin
        cnt <= '0;
        if (bit_idx == LAST_BIT) begin
          active <= 1'b0;
          txd    <= 1'b1;
        end else begin
          bit_idx <= bit_idx + 4'd1;
          txd     <= sh[0];
          sh      <= {1'b1, sh[9:1]};
        end
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/uart_resp_framer.sv
// Response-frame transmitter: COM, LEN, ADR, payload from memory, CRC-16 trailer,
// serialised back-to-back on txd with busy/done status and byte-boundary abort.
module uart_resp_framer
  import uart_pkg::*;
#(
  parameter int          BAUD_DIV  = 434,
  parameter int          STOP_BITS = 1,
  parameter int          ADR_BYTES = 2,
  parameter int          RD_LAT    = 1,
  parameter logic [15:0] CRC_POLY  = 16'h1021,
  parameter logic [15:0] CRC_INIT  = 16'hFFFF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   st,
  input  logic                   abort,
  input  logic [7:0]             com,
  input  logic [7:0]             lbl,
  input  logic [8*ADR_BYTES-1:0] adr,
  input  logic [7:0]             rd_dat,
  output logic [8*ADR_BYTES-1:0] rd_adr,
  output logic                   txd,
  output logic                   busy,
  output logic                   done
);

  localparam int ADR_W = 8 * ADR_BYTES;

  // Memory data is sampled a whole character after its address is presented.
  if (BAUD_DIV < 4 || STOP_BITS < 1 || STOP_BITS > 2 || ADR_BYTES < 1 || ADR_BYTES > 4 ||
      RD_LAT < 0 || RD_LAT >= 10 * BAUD_DIV) begin : g_bad_param
    $error("uart_resp_framer: parameter out of range");
  end

  frame_state_e state, nxt;
  logic [7:0]       com_q, lbl_q, pay_cnt, ld_dat;
  logic [ADR_W-1:0] adr_q;
  logic [15:0]      crc;
  logic [1:0]       adr_idx;
  logic             abort_q, aborting, start_ok, load, inc_rd;
  logic             bit_ce, byte_end, crc_en, rd_mode, hdr_mode, pay_last;

  assign start_ok = st && !busy && !done;
  assign aborting = abort || abort_q;
  assign rd_mode  = (com_q == COM_RD);
  assign hdr_mode = rd_mode || (com_q == COM_ACK);
  assign pay_last = (pay_cnt == lbl_q - 8'd1);
  assign crc_en   = state inside {S_COM, S_LEN, S_ADR, S_PAY};

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    nxt    = state;
    load   = 1'b0;
    ld_dat = com;
    inc_rd = 1'b0;
    if (!busy) begin
      if (start_ok) begin
        load = 1'b1;
        nxt  = S_COM;
      end
    end else if (byte_end && aborting) begin
      nxt = S_IDLE;
    end else if (byte_end) begin
      load = 1'b1;
      case (state)
        S_COM: begin
          if (hdr_mode) begin
            nxt    = S_LEN;
            ld_dat = rd_mode ? lbl_q : 8'h00;
          end else begin
            nxt    = S_CRC_H;
            ld_dat = crc[15:8];
          end
        end
        S_LEN: begin
          nxt    = S_ADR;
          ld_dat = 8'(adr_q >> (8 * (ADR_BYTES - 1)));
        end
        S_ADR: begin
          if (adr_idx != 2'd0) begin
            ld_dat = 8'(adr_q >> {adr_idx - 2'd1, 3'b000});
          end else if (rd_mode && lbl_q != 8'd0) begin
            nxt    = S_PAY;
            ld_dat = rd_dat;
            inc_rd = (lbl_q > 8'd1);
          end else begin
            nxt    = S_CRC_H;
            ld_dat = crc[15:8];
          end
        end
        S_PAY: begin
          if (pay_last) begin
            nxt    = S_CRC_H;
            ld_dat = crc[15:8];
          end else begin
            ld_dat = rd_dat;
            inc_rd = ({1'b0, pay_cnt} + 9'd2) < {1'b0, lbl_q};
          end
        end
        S_CRC_H: begin
          nxt    = S_CRC_L;
          ld_dat = crc[7:0];
        end
        default: begin
          nxt  = S_IDLE;
          load = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      com_q   <= '0;
      lbl_q   <= '0;
      adr_q   <= '0;
      rd_adr  <= '0;
      crc     <= CRC_INIT;
      adr_idx <= '0;
      pay_cnt <= '0;
      abort_q <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (busy && abort) abort_q <= 1'b1;
      if (bit_ce && crc_en) crc <= crc16_step(crc, txd, CRC_POLY);
      if (!busy) begin
        if (start_ok) begin
          state   <= nxt;
          com_q   <= com;
          lbl_q   <= lbl;
          adr_q   <= adr;
          rd_adr  <= adr;
          crc     <= CRC_INIT;
          abort_q <= 1'b0;
          busy    <= 1'b1;
        end
      end else if (byte_end) begin
        state <= nxt;
        if (nxt == S_IDLE) begin
          busy <= 1'b0;
          done <= !aborting;
        end
        if (nxt == S_ADR) adr_idx <= (state == S_LEN) ? 2'(ADR_BYTES - 1) : adr_idx - 2'd1;
        if (nxt == S_PAY) pay_cnt <= (state == S_PAY) ? pay_cnt + 8'd1 : 8'd0;
        if (inc_rd) rd_adr <= rd_adr + ADR_W'(1);
      end
    end
  end

  uart_tx_byte #(
    .BAUD_DIV (BAUD_DIV),
    .STOP_BITS(STOP_BITS)
  ) u_tx (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .dat     (ld_dat),
    .txd     (txd),
    .bit_ce  (bit_ce),
    .byte_end(byte_end)
  );

endmodule

// File: tb/tb_uart_resp_framer.sv
// Bench for uart_resp_framer: a UART receiver checks every byte against a model-filled
// scoreboard; frame length, done, rd_adr, abort, reset and 2-stop-bit cases are checked.
module tb_uart_resp_framer;
  import uart_pkg::*;

  localparam int BD = 8;

  logic        clk = 1'b0, rst_n = 1'b0, st = 1'b0, abort = 1'b0;
  logic [7:0]  com = 8'h00, lbl = 8'h00;
  logic [15:0] adr = 16'h0000;
  logic [7:0]  rd_dat, rd_dat2;
  logic [15:0] rd_adr, rd_adr2;
  logic        txd, busy, done, txd2, busy2, done2;

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_byte(input logic [15:0] a);
    return (a[7:0] + a[15:8]) ^ 8'hA5;
  endfunction

  // One-clock read latency memory for each instance.
  always @(posedge clk) begin
    rd_dat  <= mem_byte(rd_adr);
    rd_dat2 <= mem_byte(rd_adr2);
  end

  uart_resp_framer #(.BAUD_DIV(BD), .STOP_BITS(1), .ADR_BYTES(2), .RD_LAT(1),
                     .CRC_POLY(16'h1021), .CRC_INIT(16'hFFFF)) dut (
    .clk(clk), .rst_n(rst_n), .st(st), .abort(abort), .com(com), .lbl(lbl), .adr(adr),
    .rd_dat(rd_dat), .rd_adr(rd_adr), .txd(txd), .busy(busy), .done(done));

  uart_resp_framer #(.BAUD_DIV(BD), .STOP_BITS(2), .ADR_BYTES(2), .RD_LAT(1),
                     .CRC_POLY(16'h1021), .CRC_INIT(16'hFFFF)) dut2 (
    .clk(clk), .rst_n(rst_n), .st(st), .abort(abort), .com(com), .lbl(lbl), .adr(adr),
    .rd_dat(rd_dat2), .rd_adr(rd_adr2), .txd(txd2), .busy(busy2), .done(done2));

  int         n_chk = 0, n_pass = 0, rst_events = 0;
  logic [7:0] exp_q[$];
  logic [7:0] frame_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Reference frame: header, payload and CRC-16 computed bit by bit in wire order.
  task automatic build_frame(input logic [7:0] c, input logic [7:0] l, input logic [15:0] a);
    logic [15:0] crc;
    logic [7:0]  b;
    logic        fb;
    crc = 16'hFFFF;
    frame_q = {};
    frame_q.push_back(c);
    if (c == 8'h00 || c == COM_RD) begin
      frame_q.push_back((c == COM_RD) ? l : 8'h00);
      frame_q.push_back(a[15:8]);
      frame_q.push_back(a[7:0]);
      if (c == COM_RD)
        for (int k = 0; k < int'(l); k++) frame_q.push_back(mem_byte(a + 16'(k)));
    end
    foreach (frame_q[j]) begin
      b = frame_q[j];
      for (int i = 0; i < 8; i++) begin
        fb  = crc[15] ^ b[i];
        crc = {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
      end
    end
    frame_q.push_back(crc[15:8]);
    frame_q.push_back(crc[7:0]);
  endtask

  always @(negedge rst_n) rst_events++;

  // Receiver for dut: samples mid-cell; a byte cut by reset is dropped.
  always begin : rx_mon
    logic [7:0] b;
    int         ev;
    @(negedge clk);
    if (rst_n && txd === 1'b0) begin
      ev = rst_events;
      repeat (BD / 2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (BD) @(negedge clk);
        b[i] = txd;
      end
      repeat (BD) @(negedge clk);
      if (ev == rst_events && rst_n) begin
        check("stop_bit", {31'd0, txd}, 32'd1);
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL rx_extra_byte: got %0h, expected no byte", b);
        end else begin
          check("rx_byte", {24'd0, b}, {24'd0, exp_q.pop_front()});
        end
      end
    end
  end

  task automatic run_frame(input logic [7:0] c, input logic [7:0] l, input logic [15:0] a,
                           input int st_at, input bit st_on_done, input int abort_at,
                           output int bc, output int bc2, output int nd, output int nd2);
    bit prev_done;
    bc = 0; bc2 = 0; nd = 0; nd2 = 0; prev_done = 1'b0;
    @(negedge clk);
    com = c; lbl = l; adr = a; st = 1'b1;
    @(negedge clk);
    st = 1'b0; com = 8'h00; lbl = 8'h07; adr = 16'hAAAA;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (busy)  bc++;
      if (busy2) bc2++;
      if (done)  nd++;
      if (done2) nd2++;
      if (prev_done) check("st_on_done_ignored", {31'd0, busy}, 32'd0);
      prev_done = st_on_done && done;
      if (!busy && !busy2) break;
      st    = (cyc == st_at) || (st_on_done && done);
      abort = (cyc == abort_at);
      @(negedge clk);
    end
    st = 1'b0; abort = 1'b0;
    check("frame_end_in_budget", {30'd0, busy, busy2}, 32'd0);
  endtask

  typedef struct {
    logic [7:0]  c;
    logic [7:0]  l;
    logic [15:0] a;
    int          st_at;
    bit          st_on_done;
    int          nbytes;
    logic [15:0] fin_adr;
  } vec_t;

  vec_t vt[6];
  int   bc, bc2, nd, nd2;

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{8'h00, 8'h05, 16'h1234, -1, 1'b0, 6, 16'h1234};
    vt[1] = '{8'h80, 8'h03, 16'h00FE, -1, 1'b0, 9, 16'h0100};
    vt[2] = '{8'h80, 8'h02, 16'hFFFF, -1, 1'b0, 8, 16'h0000};
    vt[3] = '{8'h3C, 8'h09, 16'h5555, 100, 1'b1, 3, 16'h5555};
    vt[4] = '{8'h80, 8'h00, 16'h4321, -1, 1'b0, 6, 16'h4321};
    vt[5] = '{8'h80, 8'h01, 16'h0ABC, -1, 1'b0, 7, 16'h0ABC};

    repeat (3) @(negedge clk);
    check("reset_txd", {31'd0, txd}, 32'd1);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_rd_adr", {16'd0, rd_adr}, 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Abort during the ADR high byte: that byte completes, nothing after it.
    build_frame(8'h00, 8'h05, 16'h1234);
    for (int i = 0; i < 3; i++) exp_q.push_back(frame_q[i]);
    run_frame(8'h00, 8'h05, 16'h1234, -1, 1'b0, 180, bc, bc2, nd, nd2);
    check("abort_busy_cycles", bc, 3 * 10 * BD);
    check("abort_busy2_cycles", bc2, 3 * 11 * BD);
    check("abort_done", nd, 0);
    check("abort_done2", nd2, 0);
    check("abort_txd_idle", {31'd0, txd}, 32'd1);
    check("abort_rx_remaining", exp_q.size(), 0);

    foreach (vt[v]) begin
      build_frame(vt[v].c, vt[v].l, vt[v].a);
      foreach (frame_q[i]) exp_q.push_back(frame_q[i]);
      run_frame(vt[v].c, vt[v].l, vt[v].a, vt[v].st_at, vt[v].st_on_done, -1, bc, bc2, nd, nd2);
      check("busy_cycles", bc, vt[v].nbytes * 10 * BD);
      check("busy2_cycles", bc2, vt[v].nbytes * 11 * BD);
      check("done_count", nd, 1);
      check("done2_count", nd2, 1);
      check("rd_adr_final", {16'd0, rd_adr}, {16'd0, vt[v].fin_adr});
      check("rx_remaining", exp_q.size(), 0);
      check("txd_idle", {31'd0, txd}, 32'd1);
      repeat (3) @(negedge clk);
    end

    // Reset in the middle of the first payload byte.
    build_frame(8'h80, 8'h03, 16'h00FE);
    foreach (frame_q[i]) exp_q.push_back(frame_q[i]);
    @(negedge clk);
    com = 8'h80; lbl = 8'h03; adr = 16'h00FE; st = 1'b1;
    @(negedge clk);
    st = 1'b0;
    repeat (350) @(negedge clk);
    check("pre_reset_busy", {31'd0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_reset_txd", {31'd0, txd}, 32'd1);
    check("mid_reset_busy", {31'd0, busy}, 32'd0);
    check("mid_reset_rd_adr", {16'd0, rd_adr}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * 11 * BD) @(negedge clk);
    check("post_reset_rx_count", exp_q.size(), 5);
    exp_q.delete();

    build_frame(vt[0].c, vt[0].l, vt[0].a);
    foreach (frame_q[i]) exp_q.push_back(frame_q[i]);
    run_frame(vt[0].c, vt[0].l, vt[0].a, -1, 1'b0, -1, bc, bc2, nd, nd2);
    check("post_reset_busy_cycles", bc, 6 * 10 * BD);
    check("post_reset_done", nd, 1);
    check("post_reset_rx_remaining", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
